// File: rtl/branch_resolver.sv
// branch_resolver
//   Branch prediction and resolution for the fetch stage. A table of 2-bit
//   saturating counters and a tagged target buffer supply a next-PC guess
//   every cycle. Conditional branches and direct jumps resolve in EX, and
//   indirect jumps (jr) resolve in MEM. Resolution drives redirects, stage
//   flushes, table updates and mispredict statistics.
//
// Ports (all PCs are word addresses, byte PC [31:2]):
//   clk, rst             clock; asynchronous active-low reset
//   if_pc                PC being fetched
//   pred_taken, pred_pc  combinational prediction for if_pc
//   ex_*                 EX-stage resolve inputs (branch/jump)
//   mem_*                MEM-stage resolve inputs (jr)
//   correct_at_ex/_mem   redirect requests
//   correct_pc_at_ex/_mem  redirect PCs
//   flush_if/id/ex       pipeline squashes
//   branch_cnt, mispred_cnt  resolved and mispredicted control transfers
module branch_resolver #(
  parameter int unsigned IDX_W = 6,
  parameter int unsigned TAG_W = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [29:0] if_pc,
  output logic        pred_taken,
  output logic [29:0] pred_pc,
  input  logic        ex_valid,
  input  logic        ex_stall,
  input  logic        ex_is_branch,
  input  logic        ex_is_jump,
  input  logic        ex_taken,
  input  logic [29:0] ex_pc,
  input  logic [29:0] ex_target,
  input  logic [29:0] ex_pred_pc,
  input  logic        mem_valid,
  input  logic        mem_is_jr,
  input  logic [29:0] mem_pc,
  input  logic [29:0] mem_target,
  input  logic [29:0] mem_pred_pc,
  output logic        correct_at_ex,
  output logic [29:0] correct_pc_at_ex,
  output logic        correct_at_mem,
  output logic [29:0] correct_pc_at_mem,
  output logic        flush_if,
  output logic        flush_id,
  output logic        flush_ex,
  output logic [31:0] branch_cnt,
  output logic [31:0] mispred_cnt
);

  localparam int unsigned ENTRIES = 1 << IDX_W;

  logic [1:0]       r_bht     [ENTRIES];
  logic             r_btb_v   [ENTRIES];
  logic [TAG_W-1:0] r_btb_tag [ENTRIES];
  logic [29:0]      r_btb_tgt [ENTRIES];
  logic [31:0]      r_branch_cnt;
  logic [31:0]      r_mispred_cnt;

  logic [IDX_W-1:0] w_if_idx, w_ex_idx, w_mem_idx;
  logic [TAG_W-1:0] w_if_tag, w_ex_tag, w_mem_tag;
  logic             w_hit;
  logic             w_mem_act;
  logic             w_ex_act;
  logic [29:0]      w_ex_actual;
  logic             w_unused;

  assign w_if_idx  = if_pc[IDX_W-1:0];
  assign w_if_tag  = if_pc[IDX_W+TAG_W-1:IDX_W];
  assign w_ex_idx  = ex_pc[IDX_W-1:0];
  assign w_ex_tag  = ex_pc[IDX_W+TAG_W-1:IDX_W];
  assign w_mem_idx = mem_pc[IDX_W-1:0];
  assign w_mem_tag = mem_pc[IDX_W+TAG_W-1:IDX_W];

  // PC bits above the tag do not participate in lookup
  assign w_unused = ^{if_pc[29:IDX_W+TAG_W], ex_pc[29:IDX_W+TAG_W],
                      mem_pc[29:IDX_W+TAG_W]};

  // Lookup reads the registered tables, so a same-cycle write is seen next cycle
  always_comb begin
    w_hit      = r_btb_v[w_if_idx] && (r_btb_tag[w_if_idx] == w_if_tag);
    pred_taken = w_hit && r_bht[w_if_idx][1];
    pred_pc    = pred_taken ? r_btb_tgt[w_if_idx] : 30'(if_pc + 30'd1);
  end

  // MEM (older) correction masks the wrong-path EX instruction entirely
  always_comb begin
    w_mem_act         = rst && mem_valid && mem_is_jr;
    correct_at_mem    = w_mem_act && (mem_target != mem_pred_pc);
    correct_pc_at_mem = w_mem_act ? mem_target : '0;

    w_ex_act    = rst && ex_valid && !ex_stall && !correct_at_mem &&
                  (ex_is_branch || ex_is_jump);
    w_ex_actual = (ex_is_jump || ex_taken) ? ex_target : 30'(ex_pc + 30'd1);
    correct_at_ex    = w_ex_act && (w_ex_actual != ex_pred_pc);
    correct_pc_at_ex = w_ex_act ? w_ex_actual : '0;

    flush_if = correct_at_mem || correct_at_ex;
    flush_id = correct_at_mem || correct_at_ex;
    flush_ex = correct_at_mem;
  end

  // MEM updates come after EX updates so a shared index takes the MEM write
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned i = 0; i < ENTRIES; i++) begin
        r_bht[i]     <= 2'b01;
        r_btb_v[i]   <= 1'b0;
        r_btb_tag[i] <= '0;
        r_btb_tgt[i] <= '0;
      end
    end else begin
      if (w_ex_act) begin
        if (ex_is_branch) begin
          if (ex_taken && (r_bht[w_ex_idx] != 2'b11))
            r_bht[w_ex_idx] <= r_bht[w_ex_idx] + 2'd1;
          else if (!ex_taken && (r_bht[w_ex_idx] != 2'b00))
            r_bht[w_ex_idx] <= r_bht[w_ex_idx] - 2'd1;
        end
        if (ex_is_jump || ex_taken) begin
          r_btb_v[w_ex_idx]   <= 1'b1;
          r_btb_tag[w_ex_idx] <= w_ex_tag;
          r_btb_tgt[w_ex_idx] <= ex_target;
        end
      end
      if (w_mem_act) begin
        r_btb_v[w_mem_idx]   <= 1'b1;
        r_btb_tag[w_mem_idx] <= w_mem_tag;
        r_btb_tgt[w_mem_idx] <= mem_target;
        r_bht[w_mem_idx]     <= 2'b11;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_branch_cnt  <= '0;
      r_mispred_cnt <= '0;
    end else begin
      r_branch_cnt  <= r_branch_cnt + 32'(w_ex_act) + 32'(w_mem_act);
      r_mispred_cnt <= r_mispred_cnt + 32'(correct_at_ex) + 32'(correct_at_mem);
    end
  end

  assign branch_cnt  = r_branch_cnt;
  assign mispred_cnt = r_mispred_cnt;

endmodule

// File: tb/tb_branch_resolver.sv
module tb_branch_resolver;

  logic        clk = 1'b0;
  logic        rst;
  logic [29:0] if_pc;
  logic        pred_taken;
  logic [29:0] pred_pc;
  logic        ex_valid, ex_stall, ex_is_branch, ex_is_jump, ex_taken;
  logic [29:0] ex_pc, ex_target, ex_pred_pc;
  logic        mem_valid, mem_is_jr;
  logic [29:0] mem_pc, mem_target, mem_pred_pc;
  logic        correct_at_ex, correct_at_mem;
  logic [29:0] correct_pc_at_ex, correct_pc_at_mem;
  logic        flush_if, flush_id, flush_ex;
  logic [31:0] branch_cnt, mispred_cnt;

  branch_resolver #(.IDX_W(6), .TAG_W(8)) dut (
    .clk(clk), .rst(rst), .if_pc(if_pc),
    .pred_taken(pred_taken), .pred_pc(pred_pc),
    .ex_valid(ex_valid), .ex_stall(ex_stall), .ex_is_branch(ex_is_branch),
    .ex_is_jump(ex_is_jump), .ex_taken(ex_taken), .ex_pc(ex_pc),
    .ex_target(ex_target), .ex_pred_pc(ex_pred_pc),
    .mem_valid(mem_valid), .mem_is_jr(mem_is_jr), .mem_pc(mem_pc),
    .mem_target(mem_target), .mem_pred_pc(mem_pred_pc),
    .correct_at_ex(correct_at_ex), .correct_pc_at_ex(correct_pc_at_ex),
    .correct_at_mem(correct_at_mem), .correct_pc_at_mem(correct_pc_at_mem),
    .flush_if(flush_if), .flush_id(flush_id), .flush_ex(flush_ex),
    .branch_cnt(branch_cnt), .mispred_cnt(mispred_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [29:0] ipc;
    bit exv, exst, exbr, exj, ext;
    logic [29:0] expc, extgt, expred;
    bit memv, memjr;
    logic [29:0] mpc, mtgt, mpred;
  } stim_t;

  typedef struct {
    logic        pt;
    logic [29:0] ppc;
    logic        cex;
    logic [29:0] cpe;
    logic        cm;
    logic [29:0] cpm;
    logic        fi, fid, fex;
    logic [31:0] bc, mc;
  } exp_t;

  exp_t q[$];
  int n_pass = 0;
  int n_tot  = 0;

  // Reference model: table contents as plain integers
  int          m_ctr [64];
  bit          m_v   [64];
  int          m_tag [64];
  logic [29:0] m_tgt [64];
  logic [31:0] m_bc, m_mc;

  function automatic int idx_of(input logic [29:0] pc);
    return int'(pc % 64);
  endfunction

  function automatic int tag_of(input logic [29:0] pc);
    return int'((pc / 64) % 256);
  endfunction

  function automatic bit model_taken(input logic [29:0] pc);
    int i = idx_of(pc);
    return m_v[i] && (m_tag[i] == tag_of(pc)) && (m_ctr[i] >= 2);
  endfunction

  function automatic logic [29:0] model_ppc(input logic [29:0] pc);
    logic [29:0] nxt = pc + 30'd1;
    return model_taken(pc) ? m_tgt[idx_of(pc)] : nxt;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 64; i++) begin
      m_ctr[i] = 1; m_v[i] = 0; m_tag[i] = 0; m_tgt[i] = '0;
    end
    m_bc = 0; m_mc = 0;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  function automatic stim_t s_idle(input logic [29:0] ipc);
    stim_t s = '{default: '0};
    s.ipc = ipc;
    return s;
  endfunction

  function automatic stim_t s_br(input logic [29:0] ipc, input logic [29:0] pc,
                                 input bit taken, input logic [29:0] tgt,
                                 input logic [29:0] pred, input bit stall);
    stim_t s = s_idle(ipc);
    s.exv = 1; s.exbr = 1; s.ext = taken; s.exst = stall;
    s.expc = pc; s.extgt = tgt; s.expred = pred;
    return s;
  endfunction

  function automatic stim_t s_jmp(input logic [29:0] ipc, input logic [29:0] pc,
                                  input logic [29:0] tgt, input logic [29:0] pred);
    stim_t s = s_idle(ipc);
    s.exv = 1; s.exj = 1; s.expc = pc; s.extgt = tgt; s.expred = pred;
    return s;
  endfunction

  function automatic stim_t add_jr(input stim_t si, input logic [29:0] pc,
                                   input logic [29:0] tgt, input logic [29:0] pred);
    stim_t s = si;
    s.memv = 1; s.memjr = 1; s.mpc = pc; s.mtgt = tgt; s.mpred = pred;
    return s;
  endfunction

  // One cycle: drive after the edge, push the expectation, advance the model
  task automatic cyc(input stim_t s);
    exp_t e;
    bit mem_act, ex_act;
    logic [29:0] actual, nxt;
    int i;
    @(posedge clk); #1;
    if_pc = s.ipc;
    ex_valid = s.exv; ex_stall = s.exst; ex_is_branch = s.exbr;
    ex_is_jump = s.exj; ex_taken = s.ext; ex_pc = s.expc;
    ex_target = s.extgt; ex_pred_pc = s.expred;
    mem_valid = s.memv; mem_is_jr = s.memjr; mem_pc = s.mpc;
    mem_target = s.mtgt; mem_pred_pc = s.mpred;

    e.pt  = model_taken(s.ipc);
    e.ppc = model_ppc(s.ipc);
    mem_act = s.memv && s.memjr;
    e.cm  = mem_act && (s.mtgt != s.mpred);
    e.cpm = mem_act ? s.mtgt : 30'd0;
    ex_act = s.exv && !s.exst && !e.cm && (s.exbr || s.exj);
    nxt = s.expc + 30'd1;
    actual = (s.exj || s.ext) ? s.extgt : nxt;
    e.cex = ex_act && (actual != s.expred);
    e.cpe = ex_act ? actual : 30'd0;
    e.fi  = e.cm || e.cex;
    e.fid = e.cm || e.cex;
    e.fex = e.cm;
    e.bc  = m_bc;
    e.mc  = m_mc;
    q.push_back(e);

    m_bc = m_bc + 32'(ex_act) + 32'(mem_act);
    m_mc = m_mc + 32'(e.cex) + 32'(e.cm);
    if (ex_act) begin
      i = idx_of(s.expc);
      if (s.exbr) m_ctr[i] = s.ext ? ((m_ctr[i] < 3) ? m_ctr[i] + 1 : 3)
                                   : ((m_ctr[i] > 0) ? m_ctr[i] - 1 : 0);
      if (s.exj || s.ext) begin
        m_v[i] = 1; m_tag[i] = tag_of(s.expc); m_tgt[i] = s.extgt;
      end
    end
    if (mem_act) begin
      i = idx_of(s.mpc);
      m_v[i] = 1; m_tag[i] = tag_of(s.mpc); m_tgt[i] = s.mtgt; m_ctr[i] = 3;
    end
  endtask

  // Monitor: compares every presented cycle against the queued expectation
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("pred_taken",  32'(pred_taken),        32'(e.pt));
        chk("pred_pc",     32'(pred_pc),           32'(e.ppc));
        chk("correct_ex",  32'(correct_at_ex),     32'(e.cex));
        chk("corr_pc_ex",  32'(correct_pc_at_ex),  32'(e.cpe));
        chk("correct_mem", 32'(correct_at_mem),    32'(e.cm));
        chk("corr_pc_mem", 32'(correct_pc_at_mem), 32'(e.cpm));
        chk("flushes",     32'({flush_if, flush_id, flush_ex}), 32'({e.fi, e.fid, e.fex}));
        chk("branch_cnt",  branch_cnt,  e.bc);
        chk("mispred_cnt", mispred_cnt, e.mc);
      end
    end
  end

  logic [29:0] pool [8] = '{30'h40, 30'h80, 30'hC0, 30'h10, 30'h11, 30'h50, 30'h3FFFFFFF, 30'h13};

  initial begin
    stim_t s;
    int r;
    int waited;
    logic [29:0] nxt;
    rst = 1'b0;
    s = s_idle(30'h100);
    if_pc = s.ipc;
    {ex_valid, ex_stall, ex_is_branch, ex_is_jump, ex_taken} = '0;
    {ex_pc, ex_target, ex_pred_pc} = '0;
    {mem_valid, mem_is_jr} = '0;
    {mem_pc, mem_target, mem_pred_pc} = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #2 rst = 1'b1;

    // Reset state
    cyc(s_idle(30'h100));

    // First taken branch mispredicts, then is predicted
    cyc(s_br(30'h100, 30'h40, 1, 30'h80, 30'h41, 0));
    @(negedge clk);
    chk("plan_corr_ex", 32'(correct_at_ex), 32'd1);
    chk("plan_corr_pc", 32'(correct_pc_at_ex), 32'h80);
    cyc(s_idle(30'h40));
    @(negedge clk);
    chk("plan_pred_pc", 32'(pred_pc), 32'h80);

    // Saturation then two not-takens
    repeat (3) cyc(s_br(30'h40, 30'h40, 1, 30'h80, 30'h80, 0));
    cyc(s_br(30'h40, 30'h40, 0, 30'h80, 30'h80, 0));
    cyc(s_idle(30'h40));
    @(negedge clk);
    chk("plan_sat_taken", 32'(pred_taken), 32'd1);
    cyc(s_br(30'h40, 30'h40, 0, 30'h80, 30'h80, 0));
    cyc(s_idle(30'h40));
    @(negedge clk);
    chk("plan_nt_pc", 32'(pred_pc), 32'h41);

    // jr in MEM masks a mispredicting EX branch
    cyc(add_jr(s_br(30'h40, 30'h40, 1, 30'h90, 30'h41, 0), 30'h30, 30'h200, 30'h31));
    @(negedge clk);
    chk("plan_jr_corr", 32'(correct_at_mem), 32'd1);
    chk("plan_jr_ex_masked", 32'(correct_at_ex), 32'd0);
    chk("plan_jr_flush_ex", 32'(flush_ex), 32'd1);
    cyc(s_idle(30'h40));
    cyc(s_idle(30'h30));

    // Aliasing: 0x80 shares index 0 with 0x40 but not the tag
    cyc(s_jmp(30'h80, 30'h40, 30'h55, 30'h41));
    cyc(s_idle(30'h80));
    cyc(s_br(30'h80, 30'h80, 1, 30'h99, 30'h81, 0));
    cyc(s_idle(30'h80));
    cyc(s_idle(30'h40));

    // Stall holds a mispredicting branch for three cycles
    repeat (3) begin
      cyc(s_br(30'h10, 30'h10, 1, 30'h70, 30'h11, 1));
      @(negedge clk);
      chk("plan_stall_quiet", 32'(correct_at_ex), 32'd0);
    end
    cyc(s_br(30'h10, 30'h10, 1, 30'h70, 30'h11, 0));
    @(negedge clk);
    chk("plan_stall_release", 32'(correct_at_ex), 32'd1);
    cyc(s_idle(30'h10));
    @(negedge clk);
    chk("plan_pre_reset_pred", 32'(pred_taken), 32'd1);

    // Asynchronous reset mid-cycle
    #2;
    rst = 1'b0;
    #1;
    chk("rst_pred_taken", 32'(pred_taken), 32'd0);
    chk("rst_pred_pc", 32'(pred_pc), 32'h11);
    chk("rst_branch_cnt", branch_cnt, 32'd0);
    chk("rst_mispred_cnt", mispred_cnt, 32'd0);
    model_reset();
    @(posedge clk);
    #2 rst = 1'b1;
    cyc(s_idle(30'h10));

    // Randomized traffic
    for (int n = 0; n < 400; n++) begin
      s = s_idle(pool[$urandom_range(0, 7)]);
      r = int'($urandom_range(0, 3));
      if (r != 0) begin
        s.expc  = pool[$urandom_range(0, 7)];
        s.extgt = pool[$urandom_range(0, 7)];
        s.exv   = 1;
        s.exst  = ($urandom_range(0, 4) == 0);
        if ($urandom_range(0, 3) == 0) s.exj = 1;
        else begin s.exbr = 1; s.ext = $urandom_range(0, 1) == 1; end
        nxt = s.expc + 30'd1;
        case ($urandom_range(0, 3))
          0: s.expred = model_ppc(s.expc);
          1: s.expred = (s.exj || s.ext) ? s.extgt : nxt;
          2: s.expred = nxt;
          default: s.expred = pool[$urandom_range(0, 7)];
        endcase
      end
      if ($urandom_range(0, 5) == 0) begin
        s.memv = 1; s.memjr = 1;
        s.mpc  = pool[$urandom_range(0, 7)];
        s.mtgt = pool[$urandom_range(0, 7)];
        s.mpred = ($urandom_range(0, 1) == 1) ? s.mtgt : pool[$urandom_range(0, 7)];
      end
      cyc(s);
    end
    cyc(s_idle(30'h40));

    waited = 0;
    while (q.size() > 0 && waited < 10) begin
      @(negedge clk); #1;
      waited++;
    end
    if (q.size() > 0) chk("drain_timeout", 32'(q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
